fft_input_loader: RTL and testbench
===================================

FFT_INPUT_LOADER -- requirements
Module: fft_input_loader

Interface
REQ-001 SHALL have parameter N, default 4, sample word width = 2**N bits (two's complement), identical to the FFT stage datapath.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port s_valid  input  1  input sample valid.
REQ-005 SHALL have port s_ready  output  1  loader can accept a sample this cycle.
REQ-006 SHALL have port s_data_r  input  2**N  real part of incoming sample.
REQ-007 SHALL have port s_data_i  input  2**N  imaginary part of incoming sample.
REQ-008 SHALL have ports out_k_r, out_k_i for k=0..7  output  2**N each  frame samples in natural time order; sample k of the frame on index k.
REQ-009 SHALL have port frame_valid  output  1  out_* hold a complete 8-sample frame.
REQ-010 SHALL have port frame_ready  input  1  FFT datapath consumes the frame this cycle.

Function
REQ-011 SHALL accept a sample on every cycle with s_valid && s_ready, writing it into slot wr_idx of the current write bank.
REQ-012 SHALL use a 3-bit wr_idx, 0..7, incremented per accepted sample and wrapping 7->0.
REQ-013 SHALL implement two banks (ping-pong), each with state EMPTY, FILLING or FULL.
REQ-014 Bank transitions SHALL be: EMPTY->FILLING on first accepted sample; FILLING->FULL on acceptance at wr_idx=7; FULL->EMPTY on frame handshake while that bank is the read bank.
REQ-015 After the 8th sample is accepted, write bank select SHALL toggle on the same edge.
REQ-016 s_ready SHALL be 1 iff the current write bank is not FULL; it is combinational from registered state only, with no path from s_valid or frame_ready.
REQ-017 frame_valid SHALL be 1 iff the current read bank is FULL.
REQ-018 frame_valid SHALL rise in the cycle after the edge that accepts the 8th sample, giving a latency of 1 cycle from last-sample acceptance.
REQ-019 out_* SHALL present the read bank contents and remain stable while frame_valid=1 and frame_ready=0.
REQ-020 On frame_valid && frame_ready, the read bank SHALL be released and the read select SHALL toggle on the same edge.
REQ-021 Simultaneous release of one bank and 8th-sample fill of the other SHALL both take effect: frame_valid stays 1 with the new frame next cycle.
REQ-022 When both banks are FULL, s_ready SHALL be 0 and no sample is lost or overwritten.
REQ-023 frame_ready while frame_valid=0 SHALL be ignored.
REQ-024 Data SHALL be stored unmodified, with no scaling, reordering or sign extension; bit-reversal belongs to the downstream stage wiring.

Reset
REQ-025 On rst=1 at a clock edge, both banks SHALL go EMPTY, wr_idx=0 and both bank selects=0.
REQ-026 On reset, all storage and out_* SHALL be cleared to 0, with frame_valid=0 and s_ready=1 in the following cycle.
REQ-027 Reset mid-frame SHALL discard any partial frame, and a pending FULL frame SHALL be dropped without a handshake.
REQ-028 rst SHALL take priority over simultaneous s_valid and frame_ready.

Structure
REQ-029 Shared include fft_defs.vh SHALL define FFT_POINTS=8 and FFT_LOG2_POINTS=3.
REQ-030 Bank state encodings SHALL be localparams in that include.
REQ-031 One sub-module, fft_frame_bank, SHALL be instantiated twice: an 8-entry complex register bank with write enable, 3-bit address, and parallel read of all 8 entries.
REQ-032 Bank-state, index and select logic SHALL reside in fft_input_loader.

Verification
REQ-033 Scenario: with N=4 and frame_ready=1, stream samples (k, -k) for k=0..7 -> frame_valid rises one cycle after the 8th sample, with out_k_r=k and out_k_i=-k.
REQ-034 Scenario: with frame_ready=0, stream 20 samples -> s_ready drops after 16 accepted samples and first frame=samples 0..7; after one handshake, second frame=samples 8..15 and s_ready=1.
REQ-035 Scenario: with continuous s_valid=1 and frame_ready=1 -> throughput of one sample per cycle, no s_ready deassertion, frames exact and back-to-back.
REQ-036 Scenario: assert rst after 5 samples, then stream 8 new samples -> frame contains only the new samples.
REQ-037 Scenario: hold frame_ready=0 for 10 cycles with frame_valid=1 -> out_* stable throughout.
REQ-038 Scenario: handshake on the same cycle as the 8th sample of the other bank -> frame_valid remains 1 and the new frame appears next cycle.
REQ-039 Scenario: values 0x7FFF and 0x8000 -> passed bit-exact.

Source files
------------

// File: rtl/fft_input_loader_pkg.sv
// Package for the FFT input loader: shared definitions, bank state type and index helper.
package fft_input_loader_pkg;

`include "fft_defs.vh"

   typedef logic [1:0] bank_state_t;

   // Slot index advance; the natural 3-bit wrap gives 7 -> 0.
   function automatic logic [FFT_LOG2_POINTS-1:0] next_idx(input logic [FFT_LOG2_POINTS-1:0] idx);
      return idx + FFT_LOG2_POINTS'(1);
   endfunction

endpackage

// File: rtl/fft_defs.vh
// Shared FFT definitions: frame geometry and bank state encodings.
`ifndef FFT_DEFS_VH
`define FFT_DEFS_VH

localparam int FFT_POINTS      = 8;
localparam int FFT_LOG2_POINTS = 3;

localparam logic [1:0] BANK_EMPTY   = 2'd0;
localparam logic [1:0] BANK_FILLING = 2'd1;
localparam logic [1:0] BANK_FULL    = 2'd2;

`endif

// File: rtl/fft_frame_bank.sv
// 8-entry complex register bank: single write port, all entries readable in parallel.
module fft_frame_bank
   import fft_input_loader_pkg::*;
#(
   parameter int W = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         we,
   input  logic [FFT_LOG2_POINTS-1:0]   addr,
   input  logic [W-1:0]                 wr_r,
   input  logic [W-1:0]                 wr_i,
   output logic [FFT_POINTS*W-1:0]      rd_r,
   output logic [FFT_POINTS*W-1:0]      rd_i
);

   logic [W-1:0] mem_r_reg [FFT_POINTS];
   logic [W-1:0] mem_i_reg [FFT_POINTS];

   genvar gi;
   generate
      for (gi = 0; gi < FFT_POINTS; gi++) begin : g_slot
         // Each slot captures the incoming sample when addressed; reset clears it.
         always_ff @(posedge clk) begin
            if (rst) begin
               mem_r_reg[gi] <= '0;
               mem_i_reg[gi] <= '0;
            end else if (we && addr == FFT_LOG2_POINTS'(gi)) begin
               mem_r_reg[gi] <= wr_r;
               mem_i_reg[gi] <= wr_i;
            end
         end

         assign rd_r[gi*W +: W] = mem_r_reg[gi];
         assign rd_i[gi*W +: W] = mem_i_reg[gi];
      end
   endgenerate

endmodule

// File: rtl/fft_input_loader.sv
// Ping-pong frame loader: collects 8 complex samples per bank and presents a full
// frame to the FFT datapath while the other bank fills.
module fft_input_loader
   import fft_input_loader_pkg::*;
#(
   parameter int N = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [2**N-1:0]   s_data_r,
   input  logic [2**N-1:0]   s_data_i,
   output logic [2**N-1:0]   out_0_r,
   output logic [2**N-1:0]   out_0_i,
   output logic [2**N-1:0]   out_1_r,
   output logic [2**N-1:0]   out_1_i,
   output logic [2**N-1:0]   out_2_r,
   output logic [2**N-1:0]   out_2_i,
   output logic [2**N-1:0]   out_3_r,
   output logic [2**N-1:0]   out_3_i,
   output logic [2**N-1:0]   out_4_r,
   output logic [2**N-1:0]   out_4_i,
   output logic [2**N-1:0]   out_5_r,
   output logic [2**N-1:0]   out_5_i,
   output logic [2**N-1:0]   out_6_r,
   output logic [2**N-1:0]   out_6_i,
   output logic [2**N-1:0]   out_7_r,
   output logic [2**N-1:0]   out_7_i,
   output logic              frame_valid,
   input  logic              frame_ready
);

   localparam int W = 2**N;
   localparam logic [FFT_LOG2_POINTS-1:0] LAST_IDX = FFT_LOG2_POINTS'(FFT_POINTS - 1);

   bank_state_t                   bank_state_reg [2];
   bank_state_t                   bank_state_next [2];
   logic [FFT_LOG2_POINTS-1:0]    wr_idx_reg, wr_idx_next;
   logic                          wr_sel_reg, wr_sel_next;
   logic                          rd_sel_reg, rd_sel_next;
   logic                          accept;
   logic                          frame_release;

   logic [FFT_POINTS*W-1:0]       bank_rd_r [2];
   logic [FFT_POINTS*W-1:0]       bank_rd_i [2];
   logic [FFT_POINTS*W-1:0]       rd_r;
   logic [FFT_POINTS*W-1:0]       rd_i;

   // State register: bank states, write slot and the two bank selects.
   always_ff @(posedge clk) begin
      if (rst) begin
         bank_state_reg[0] <= BANK_EMPTY;
         bank_state_reg[1] <= BANK_EMPTY;
         wr_idx_reg        <= '0;
         wr_sel_reg        <= 1'b0;
         rd_sel_reg        <= 1'b0;
      end else begin
         bank_state_reg[0] <= bank_state_next[0];
         bank_state_reg[1] <= bank_state_next[1];
         wr_idx_reg        <= wr_idx_next;
         wr_sel_reg        <= wr_sel_next;
         rd_sel_reg        <= rd_sel_next;
      end
   end

   // Next state: fill and release can hit different banks on one edge and both apply;
   // they never target the same bank because fill needs non-FULL and release needs FULL.
   always_comb begin
      bank_state_next[0] = bank_state_reg[0];
      bank_state_next[1] = bank_state_reg[1];
      wr_idx_next        = wr_idx_reg;
      wr_sel_next        = wr_sel_reg;
      rd_sel_next        = rd_sel_reg;
      if (accept) begin
         wr_idx_next = next_idx(wr_idx_reg);
         if (wr_idx_reg == LAST_IDX) begin
            bank_state_next[wr_sel_reg] = BANK_FULL;
            wr_sel_next                 = ~wr_sel_reg;
         end else begin
            bank_state_next[wr_sel_reg] = BANK_FILLING;
         end
      end
      if (frame_release) begin
         bank_state_next[rd_sel_reg] = BANK_EMPTY;
         rd_sel_next                 = ~rd_sel_reg;
      end
   end

   // Handshake outputs: derived only from registered bank state.
   always_comb begin
      s_ready       = (bank_state_reg[wr_sel_reg] != BANK_FULL);
      frame_valid   = (bank_state_reg[rd_sel_reg] == BANK_FULL);
      accept        = s_valid && s_ready;
      frame_release = frame_valid && frame_ready;
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_bank
         fft_frame_bank #(.W(W)) u_bank (
            .clk  (clk),
            .rst  (rst),
            .we   (accept && (wr_sel_reg == 1'(gi))),
            .addr (wr_idx_reg),
            .wr_r (s_data_r),
            .wr_i (s_data_i),
            .rd_r (bank_rd_r[gi]),
            .rd_i (bank_rd_i[gi])
         );
      end
   endgenerate

   assign rd_r = bank_rd_r[rd_sel_reg];
   assign rd_i = bank_rd_i[rd_sel_reg];

   assign out_0_r = rd_r[0*W +: W];
   assign out_0_i = rd_i[0*W +: W];
   assign out_1_r = rd_r[1*W +: W];
   assign out_1_i = rd_i[1*W +: W];
   assign out_2_r = rd_r[2*W +: W];
   assign out_2_i = rd_i[2*W +: W];
   assign out_3_r = rd_r[3*W +: W];
   assign out_3_i = rd_i[3*W +: W];
   assign out_4_r = rd_r[4*W +: W];
   assign out_4_i = rd_i[4*W +: W];
   assign out_5_r = rd_r[5*W +: W];
   assign out_5_i = rd_i[5*W +: W];
   assign out_6_r = rd_r[6*W +: W];
   assign out_6_i = rd_i[6*W +: W];
   assign out_7_r = rd_r[7*W +: W];
   assign out_7_i = rd_i[7*W +: W];

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed bench for fft_input_loader: inputs driven and outputs sampled on the falling edge.
module tb_fft_input_loader;

   localparam int N = 4;
   localparam int W = 2**N;

   logic          clk = 1'b0;
   logic          rst;
   logic          s_valid;
   logic          s_ready;
   logic [W-1:0]  s_data_r;
   logic [W-1:0]  s_data_i;
   logic [W-1:0]  out_r [8];
   logic [W-1:0]  out_i [8];
   logic          frame_valid;
   logic          frame_ready;

   logic [W-1:0]  exp_r [8];
   logic [W-1:0]  exp_i [8];

   int n_checks = 0;
   int n_fail   = 0;
   int sent;
   logic acc;
   logic [W-1:0] v;

   always #5 clk = ~clk;

   fft_input_loader #(.N(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data_r    (s_data_r),
      .s_data_i    (s_data_i),
      .out_0_r     (out_r[0]),
      .out_0_i     (out_i[0]),
      .out_1_r     (out_r[1]),
      .out_1_i     (out_i[1]),
      .out_2_r     (out_r[2]),
      .out_2_i     (out_i[2]),
      .out_3_r     (out_r[3]),
      .out_3_i     (out_i[3]),
      .out_4_r     (out_r[4]),
      .out_4_i     (out_i[4]),
      .out_5_r     (out_r[5]),
      .out_5_i     (out_i[5]),
      .out_6_r     (out_r[6]),
      .out_6_i     (out_i[6]),
      .out_7_r     (out_r[7]),
      .out_7_i     (out_i[7]),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic check_frame(input string tag);
      for (int k = 0; k < 8; k++) begin
         check($sformatf("%s_r%0d", tag, k), 32'(out_r[k]), 32'(exp_r[k]));
         check($sformatf("%s_i%0d", tag, k), 32'(out_i[k]), 32'(exp_i[k]));
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; s_valid = 1'b0; frame_ready = 1'b0;
      s_data_r = '0; s_data_i = '0;
      @(negedge clk);
      step();
      check("rst_fv", 32'(frame_valid), 32'd0);
      check("rst_ready", 32'(s_ready), 32'd1);
      check("rst_out0r", 32'(out_r[0]), 32'd0);
      check("rst_out7i", 32'(out_i[7]), 32'd0);
      rst = 1'b0;

      // (k, -k) frame with frame_ready held high; frame_ready ignored while no frame
      frame_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         s_valid = 1'b1; s_data_r = 16'(k); s_data_i = 16'(-k);
         check("s1_ready", 32'(s_ready), 32'd1);
         check("s1_fv_low", 32'(frame_valid), 32'd0);
         step();
      end
      s_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin exp_r[k] = 16'(k); exp_i[k] = 16'(-k); end
      check("s1_fv", 32'(frame_valid), 32'd1);
      check_frame("s1");
      step();
      check("s1_fv_done", 32'(frame_valid), 32'd0);
      check("s1_ready_done", 32'(s_ready), 32'd1);

      // Back-pressure: 20 offered, 16 accepted
      frame_ready = 1'b0;
      sent = 0;
      for (int c = 0; c < 20; c++) begin
         s_valid = 1'b1; s_data_r = 16'(100 + sent); s_data_i = 16'(200 + sent);
         acc = s_ready;
         step();
         if (acc) sent++;
      end
      s_valid = 1'b0;
      check("s2_sent", 32'(sent), 32'd16);
      check("s2_ready_low", 32'(s_ready), 32'd0);
      check("s2_fv", 32'(frame_valid), 32'd1);
      for (int k = 0; k < 8; k++) begin exp_r[k] = 16'(100 + k); exp_i[k] = 16'(200 + k); end
      check_frame("s2_f0");
      frame_ready = 1'b1;
      step();
      frame_ready = 1'b0;
      check("s2_fv1", 32'(frame_valid), 32'd1);
      check("s2_ready_back", 32'(s_ready), 32'd1);
      for (int k = 0; k < 8; k++) begin exp_r[k] = 16'(108 + k); exp_i[k] = 16'(208 + k); end
      check_frame("s2_f1");
      for (int j = 0; j < 5; j++) begin
         s_valid = 1'b1; s_data_r = 16'(116 + j); s_data_i = 16'(216 + j);
         step();
      end
      s_valid = 1'b0;
      check("s2_fv_pending", 32'(frame_valid), 32'd1);

      // Reset mid-frame with a pending full frame; reset beats s_valid and frame_ready
      rst = 1'b1; s_valid = 1'b1; frame_ready = 1'b1;
      s_data_r = 16'hDEAD; s_data_i = 16'hBEEF;
      step();
      rst = 1'b0; s_valid = 1'b0; frame_ready = 1'b0;
      check("s4_fv", 32'(frame_valid), 32'd0);
      check("s4_ready", 32'(s_ready), 32'd1);
      check("s4_out0r", 32'(out_r[0]), 32'd0);
      check("s4_out3i", 32'(out_i[3]), 32'd0);
      for (int k = 0; k < 8; k++) begin
         s_valid = 1'b1; s_data_r = 16'(300 + k); s_data_i = 16'hFF00 + 16'(k);
         step();
      end
      s_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin exp_r[k] = 16'(300 + k); exp_i[k] = 16'hFF00 + 16'(k); end
      check("s4_fv_new", 32'(frame_valid), 32'd1);
      check_frame("s4");

      // Hold frame_ready low 10 cycles while the other bank fills
      sent = 0;
      for (int c = 0; c < 10; c++) begin
         s_valid = 1'b1; s_data_r = 16'(500 + sent); s_data_i = 16'(600 + sent);
         check("s5_fv_hold", 32'(frame_valid), 32'd1);
         check("s5_out0r_hold", 32'(out_r[0]), 32'd300);
         check("s5_out7i_hold", 32'(out_i[7]), 32'hFF07);
         acc = s_ready;
         step();
         if (acc) sent++;
      end
      s_valid = 1'b0;
      check("s5_sent", 32'(sent), 32'd8);
      check_frame("s5_stable");
      frame_ready = 1'b1;
      step();
      frame_ready = 1'b0;
      check("s5_fv_next", 32'(frame_valid), 32'd1);
      for (int k = 0; k < 8; k++) begin exp_r[k] = 16'(500 + k); exp_i[k] = 16'(600 + k); end
      check_frame("s5_next");
      frame_ready = 1'b1;
      step();
      frame_ready = 1'b0;
      check("s5_fv_done", 32'(frame_valid), 32'd0);

      // Continuous streaming: one sample per cycle, back-to-back frames
      frame_ready = 1'b1;
      for (int c = 0; c < 24; c++) begin
         v = 16'h1000 + 16'(c * 257);
         s_valid = 1'b1; s_data_r = v; s_data_i = ~v;
         check("s3_ready", 32'(s_ready), 32'd1);
         step();
         check("s3_fv", 32'(frame_valid), 32'((c % 8) == 7));
         if ((c % 8) == 7) begin
            for (int k = 0; k < 8; k++) begin
               exp_r[k] = 16'h1000 + 16'((c - 7 + k) * 257);
               exp_i[k] = ~exp_r[k];
            end
            check_frame($sformatf("s3_f%0d", c / 8));
         end
      end
      s_valid = 1'b0;
      step();
      frame_ready = 1'b0;
      check("s3_fv_done", 32'(frame_valid), 32'd0);

      // Extreme values, then release coinciding with the other bank's 8th sample
      for (int k = 0; k < 8; k++) begin
         s_valid = 1'b1;
         s_data_r = (k % 2 == 1) ? 16'h8000 : 16'h7FFF;
         s_data_i = (k % 2 == 1) ? 16'h7FFF : 16'h8000;
         step();
      end
      for (int k = 0; k < 8; k++) begin
         exp_r[k] = (k % 2 == 1) ? 16'h8000 : 16'h7FFF;
         exp_i[k] = (k % 2 == 1) ? 16'h7FFF : 16'h8000;
      end
      check("s6_fv_a", 32'(frame_valid), 32'd1);
      check_frame("s6_a");
      for (int k = 0; k < 8; k++) begin
         s_valid = 1'b1; s_data_r = 16'h0A00 + 16'(k); s_data_i = 16'hF500 + 16'(k);
         frame_ready = (k == 7);
         check("s6_fv_hold", 32'(frame_valid), 32'd1);
         check("s6_out1r_hold", 32'(out_r[1]), 32'h8000);
         step();
      end
      s_valid = 1'b0; frame_ready = 1'b0;
      check("s6_fv_b", 32'(frame_valid), 32'd1);
      check("s6_ready_b", 32'(s_ready), 32'd1);
      for (int k = 0; k < 8; k++) begin exp_r[k] = 16'h0A00 + 16'(k); exp_i[k] = 16'hF500 + 16'(k); end
      check_frame("s6_b");
      frame_ready = 1'b1;
      step();
      frame_ready = 1'b0;
      check("s6_fv_done", 32'(frame_valid), 32'd0);

      // Reset drops a full frame without a handshake
      for (int k = 0; k < 8; k++) begin
         s_valid = 1'b1; s_data_r = 16'h0055 + 16'(k); s_data_i = 16'h0066 + 16'(k);
         step();
      end
      check("s7_fv", 32'(frame_valid), 32'd1);
      rst = 1'b1; s_valid = 1'b1;
      step();
      rst = 1'b0; s_valid = 1'b0;
      check("s7_fv_drop", 32'(frame_valid), 32'd0);
      check("s7_ready", 32'(s_ready), 32'd1);
      check("s7_out2r", 32'(out_r[2]), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
